// File: rtl/lfsr_pkg.sv
// Shared definitions for the 10-bit XNOR PRBS checker (taps 9 and 6).
package lfsr_pkg;

    localparam int unsigned LFSR_W = 10;
    localparam int unsigned TAP_HI = 9;
    localparam int unsigned TAP_LO = 6;
    localparam logic [LFSR_W-1:0] LOCKUP = 10'h3FF;

    typedef enum logic [1:0] {
        FILL,
        ACQUIRE,
        LOCKED
    } chk_state_t;

    function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] hist);
        return ~(hist[TAP_HI] ^ hist[TAP_LO]);
    endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising receive checker for the 10-bit XNOR PRBS stream.
// Optional lock-up detection is enabled with `define LFSR_CHK_STUCK_EN.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_MATCHES = 16,
    parameter int unsigned LOSS_ERRORS  = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic             stuck
);

    localparam int unsigned MatchW = $clog2(LOCK_MATCHES + 1);
    localparam int unsigned MissW  = $clog2(LOSS_ERRORS + 1);

    chk_state_t        state_q, state_d;
    logic [LFSR_W-1:0] hist_q, hist_d;
    logic [3:0]        fill_q, fill_d;
    logic [MatchW-1:0] match_q, match_d;
    logic [MissW-1:0]  miss_q, miss_d;
    logic              err_q, err_d;
    logic              locked_q;
    logic              pred;
    logic              mismatch;
    logic              cnt_inc;
    logic              hold_match;

`ifdef LFSR_CHK_STUCK_EN
    logic stuck_q;

    // Holding at 0 keeps a constant-1 stream from ever reaching lock.
    assign hold_match = stuck_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_q <= 1'b0;
        end else begin
            stuck_q <= (state_d != FILL) && (hist_d == LOCKUP);
        end
    end

    assign stuck = stuck_q;
`else
    assign hold_match = 1'b0;
    assign stuck      = 1'b0;
`endif

    assign pred     = lfsr_next_bit(hist_q);
    assign mismatch = (bit_in != pred);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        cnt_inc = 1'b0;

        if (bit_valid) begin
            unique case (state_q)
                FILL: begin
                    hist_d = {hist_q[LFSR_W-2:0], bit_in};
                    if (fill_q == 4'(LFSR_W - 1)) begin
                        state_d = ACQUIRE;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                end
                ACQUIRE: begin
                    hist_d = {hist_q[LFSR_W-2:0], bit_in};
                    if (mismatch || hold_match) begin
                        match_d = '0;
                    end else if (match_q == MatchW'(LOCK_MATCHES - 1)) begin
                        state_d = LOCKED;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + {{(MatchW-1){1'b0}}, 1'b1};
                    end
                end
                LOCKED: begin
                    // Shift the local reference so a corrupted bit counts only once.
                    hist_d = {hist_q[LFSR_W-2:0], pred};
                    if (mismatch) begin
                        err_d   = 1'b1;
                        cnt_inc = 1'b1;
                        if (miss_q == MissW'(LOSS_ERRORS - 1)) begin
                            state_d = FILL;
                            fill_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + {{(MissW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            hist_q   <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
            locked_q <= (state_d == LOCKED);
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (cnt_inc),
        .count(err_count)
    );

    assign locked = locked_q;
    assign err    = err_q;

endmodule
